titan_fetch_unit: RTL
=====================

Name: titan_fetch_unit

Overview:
Parametrised successor to the Titan IF stage. It fetches from the instruction bus with a Wishbone-classic handshake and buffers instructions in a FIFO prefetch queue of depth FIFO_DEPTH. It delivers {pc, instruction, exception flags} to ID with a valid/ready handshake. Redirects (branch, jump, trap) flush the queue and discard in-flight responses, and fetch-address faults are tagged precisely.

Parameters:
RESET_ADDR, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch queue entries; power of two, >= 2
NOP_INST, 32'h0000_0013, instruction field value for faulting entries

Ports:
clk_i  input  1  clock; all state on rising edge
rst_i  input  1  synchronous, active-high reset
redirect_i  input  1  take redirect_addr_i this cycle (branch/jump/trap)
redirect_addr_i  input  32  new fetch address
iport_addr_o  output  32  bus address (word aligned)
iport_cyc_o  output  1  bus cycle
iport_stb_o  output  1  bus strobe
iport_data_i  input  32  read data
iport_ack_i  input  1  transfer done
iport_err_i  input  1  bus access fault
if_pc_o  output  32  next fetch address (fetch PC register)
id_valid_o  output  1  queue head valid
id_ready_i  input  1  ID consumes head (de-asserted = ID stall)
id_pc_o  output  32  head PC
id_instruction_o  output  32  head instruction
id_exc_addr_if_o  output  1  head: misaligned fetch address
id_bus_access_fault_o  output  1  head: bus error on fetch

Behaviour:
- Reset: fetch PC = RESET_ADDR; queue empty; id_valid_o=0, id_* = 0; iport_cyc_o=iport_stb_o=0; iport_addr_o=0; state IDLE. A reset asserted mid-transfer drops cyc/stb in the next cycle and discards the pending response.
- States: IDLE, REQ, DRAIN, HALT.
- IDLE: if misaligned (pc[1:0]!=0) and queue has space: push {pc, NOP_INST, exc_addr=1}, go HALT with no bus access. Else if count + pending < FIFO_DEPTH: go REQ, drive addr=pc, cyc=stb=1.
- REQ: hold addr/cyc/stb stable until ack or err.
  - On ack: push {addr, data, 0, 0}; pc += 4 (32-bit wrap); drop cyc/stb for one cycle; return to IDLE.
  - On err: push {addr, NOP_INST, 0, fault=1}; go HALT.
- Space is reserved at issue, so a response never finds the queue full. At most one outstanding transfer.
- DRAIN: entered when redirect_i arrives in REQ without ack/err that cycle. Keep cyc/stb until ack/err, discard the data, then go IDLE.
- HALT: no bus activity until redirect_i.
- Redirect (any state, top priority):
  - Same cycle: flush queue (count=0, id_valid_o=0 next cycle); fetch PC = redirect_addr_i.
  - If ack/err coincides with redirect: the response is discarded and the state goes to IDLE.
  - From REQ without response: go DRAIN. Otherwise go IDLE.
- Queue: show-ahead; head fields drive id_* directly from storage. Pop when id_valid_o && id_ready_i.
  - Push and pop in the same cycle: count unchanged.
  - Pop of the last entry with no push: id_valid_o=0 next cycle. When invalid, id_* hold their last value.
  - Pointers wrap modulo FIFO_DEPTH. Count is a log2(FIFO_DEPTH)+1-bit field.
- Latency:
  - Redirect at edge N: stb high in cycle N+1 (from IDLE).
  - Zero-wait ack in N+1: entry visible with id_valid_o=1 in N+2.
  - Steady state: one instruction per 2 cycles.
- A bus error or misalignment never increments pc; the faulting PC is reported exactly.
- iport_addr_o[1:0] is always 0 while stb=1.

Test Plan:
- Reset with RESET_ADDR=0x100, zero-wait ack, id_ready_i=1 -> addresses 0x100, 0x104, 0x108 issued; ID sees pc 0x100/0x104/0x108 in order with matching data; both flags 0.
- id_ready_i=0, FIFO_DEPTH=4 -> exactly 4 fetches complete, then cyc/stb stay 0; raising ready drains 4 entries in order and fetching resumes at base+16.
- Ack delayed 3 cycles, redirect_i to 0x200 in the first wait cycle -> state DRAIN; late data not enqueued; next stb has addr 0x200; first id_pc_o = 0x200.
- Redirect to 0x202 -> no bus cycle; one entry {pc=0x202, inst=0x00000013, exc_addr=1}; no further fetch until redirect to 0x300 resumes at 0x300.
- iport_err_i on fetch of 0x40 -> entry {pc=0x40, fault=1, NOP}; bus idle afterwards; queue contents older than 0x40 delivered first.
- rst_i asserted during REQ with queue holding 2 entries -> next cycle cyc/stb=0, id_valid_o=0; a late ack is ignored; fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/titan_fetch_unit.sv
// Instruction fetch stage: Wishbone-classic reads into a show-ahead prefetch queue feeding ID.
// Latency: stb one cycle after a redirect; a zero-wait ack makes the entry visible the next cycle.
// Backpressure: a fetch is issued only when the queue has a free slot; ID stalls via id_ready_i.
module titan_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  output logic [31:0] if_pc_o,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instruction_o,
  output logic        id_exc_addr_if_o,
  output logic        id_bus_access_fault_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc_addr;
    logic        fault;
  } entry_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          mem_q [FIFO_DEPTH];
  logic            push;
  entry_t          push_entry;
  logic            flush;
  logic            pop;
  logic [PW-1:0]   disp_ptr;
  entry_t          head;

  assign iport_cyc_o  = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign iport_stb_o  = iport_cyc_o;
  assign iport_addr_o = addr_q;
  assign if_pc_o      = pc_q;
  assign id_valid_o   = (count_q != '0);
  assign pop          = id_valid_o && id_ready_i;

  // When empty, show the most recently consumed slot so id_* hold their last value.
  assign disp_ptr = (count_q == '0) ? (rd_ptr_q - PW'(1)) : rd_ptr_q;
  assign head     = mem_q[disp_ptr];

  assign id_pc_o               = head.pc;
  assign id_instruction_o      = head.inst;
  assign id_exc_addr_if_o      = head.exc_addr;
  assign id_bus_access_fault_o = head.fault;

  // Fetch FSM: issue, response capture, drain of abandoned transfers; redirect overrides all.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    push_entry = '0;
    flush      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pc_q[1:0] != 2'b00) begin
          if (count_q < DEPTH_C) begin
            push       = 1'b1;
            push_entry = '{pc: pc_q, inst: NOP_INST, exc_addr: 1'b1, fault: 1'b0};
            state_d    = S_HALT;
          end
        end else if (count_q < DEPTH_C) begin
          addr_d  = pc_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (iport_ack_i) begin
          push       = 1'b1;
          push_entry = '{pc: addr_q, inst: iport_data_i, exc_addr: 1'b0, fault: 1'b0};
          pc_d       = pc_q + 32'd4;
          state_d    = S_IDLE;
        end else if (iport_err_i) begin
          push       = 1'b1;
          push_entry = '{pc: addr_q, inst: NOP_INST, exc_addr: 1'b0, fault: 1'b1};
          state_d    = S_HALT;
        end
      end
      S_DRAIN: begin
        if (iport_ack_i || iport_err_i) state_d = S_IDLE;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
    if (redirect_i) begin
      flush   = 1'b1;
      push    = 1'b0;
      pc_d    = redirect_addr_i;
      state_d = (state_q == S_REQ && !iport_ack_i && !iport_err_i) ? S_DRAIN : S_IDLE;
    end
  end

  // Queue bookkeeping; a flush parks the pointers just past the old head so it stays displayed.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d = '0;
      if (count_q != '0) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        wr_ptr_d = rd_ptr_q + PW'(1);
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, fetch PC, bus address and queue pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_ADDR;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; cleared on reset so id_* read zero before the first entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule
